// File: rtl/dp_sequencer.sv
// Multi-cycle sequencer for the register-file / ALU / immediate-mux datapath.
// Optional OVERFLOW_TRAP_EN adds a trap output that blocks writeback of overflowing ADD/SUB.
module dp_sequencer #(
  parameter int unsigned EXEC_CYCLES      = 1,
  parameter bit          ZERO_REG_PROTECT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [4:0]  read1,
  output logic [4:0]  read2,
  output logic [4:0]  write_addr,
  output logic        reg_we,
  output logic [3:0]  alu_op,
  output logic [15:0] inm,
  output logic        sel,
  input  logic        zero_in,
  input  logic        overflow_in,
  input  logic        carry_in,
  output logic        zero_out,
  output logic        overflow_out,
  output logic        carry_out,
  output logic        illegal,
  output logic        done,
  output logic        busy
`ifdef OVERFLOW_TRAP_EN
  ,
  output logic        trap
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_WB, S_DONE
  } state_t;

  state_t state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [3:0] dec_op;
  logic [4:0] dec_waddr;
  logic       dec_sel, dec_ill;
  logic       accept_c, exec_last_c, we_ok_c;
  logic       ready_d, busy_d, done_d, we_d;

  assign accept_c    = (state == S_IDLE) && instr_valid;
  assign exec_last_c = (state == S_EXEC) && (cnt == '0);

  // Instruction decode, applied to the incoming word at acceptance
  always_comb begin
    dec_op    = ALU_AND;
    dec_sel   = 1'b0;
    dec_waddr = '0;
    dec_ill   = 1'b0;
    case (instr[31:26])
      6'h00: begin
        dec_waddr = instr[15:11];
        case (instr[5:0])
          6'h20:   dec_op = ALU_ADD;
          6'h22:   dec_op = ALU_SUB;
          6'h24:   dec_op = ALU_AND;
          6'h25:   dec_op = ALU_OR;
          6'h27:   dec_op = ALU_NOR;
          6'h2A:   dec_op = ALU_SLT;
          default: dec_ill = 1'b1;
        endcase
      end
      6'h08:   begin dec_waddr = instr[20:16]; dec_sel = 1'b1; dec_op = ALU_ADD; end
      6'h0C:   begin dec_waddr = instr[20:16]; dec_sel = 1'b1; dec_op = ALU_AND; end
      6'h0D:   begin dec_waddr = instr[20:16]; dec_sel = 1'b1; dec_op = ALU_OR;  end
      6'h0A:   begin dec_waddr = instr[20:16]; dec_sel = 1'b1; dec_op = ALU_SLT; end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_op    = ALU_AND;
      dec_sel   = 1'b0;
      dec_waddr = '0;
    end
  end

`ifdef OVERFLOW_TRAP_EN
  logic arith_q, trap_d;
  logic dec_arith;
  assign dec_arith = !dec_ill && ((dec_op == ALU_ADD) || (dec_op == ALU_SUB));
  assign we_ok_c   = !illegal && !(ZERO_REG_PROTECT && (write_addr == 5'd0))
                     && !(arith_q && overflow_in);
`else
  assign we_ok_c   = !illegal && !(ZERO_REG_PROTECT && (write_addr == 5'd0));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (instr_valid) next_state = S_DECODE;
      S_DECODE: next_state = S_EXEC;
      S_EXEC:   if (cnt == '0) next_state = S_WB;
      S_WB:     next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Control outputs are registered, so compute their values for the upcoming state
  always_comb begin
    ready_d = (next_state == S_IDLE);
    busy_d  = (next_state != S_IDLE);
    done_d  = (next_state == S_DONE);
    we_d    = (next_state == S_WB) && we_ok_c;
`ifdef OVERFLOW_TRAP_EN
    trap_d  = trap;
    if (accept_c)             trap_d = 1'b0;
    else if (state == S_WB)   trap_d = arith_q && overflow_out;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_ready  <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      reg_we       <= 1'b0;
      read1        <= '0;
      read2        <= '0;
      write_addr   <= '0;
      alu_op       <= '0;
      inm          <= '0;
      sel          <= 1'b0;
      illegal      <= 1'b0;
      zero_out     <= 1'b0;
      overflow_out <= 1'b0;
      carry_out    <= 1'b0;
      cnt          <= '0;
`ifdef OVERFLOW_TRAP_EN
      arith_q      <= 1'b0;
      trap         <= 1'b0;
`endif
    end else begin
      instr_ready <= ready_d;
      busy        <= busy_d;
      done        <= done_d;
      reg_we      <= we_d;
      if (accept_c) begin
        read1      <= instr[25:21];
        read2      <= instr[20:16];
        write_addr <= dec_waddr;
        alu_op     <= dec_op;
        inm        <= instr[15:0];
        sel        <= dec_sel;
        illegal    <= dec_ill;
`ifdef OVERFLOW_TRAP_EN
        arith_q    <= dec_arith;
`endif
      end
      // EXEC settle counter: loaded while in DECODE, exits EXEC when it reaches zero
      if (state == S_DECODE)                   cnt <= CNT_W'(EXEC_CYCLES - 1);
      else if ((state == S_EXEC) && cnt != '0) cnt <= cnt - CNT_W'(1);
      if (exec_last_c) begin
        zero_out     <= zero_in;
        overflow_out <= overflow_in;
        carry_out    <= carry_in;
      end
`ifdef OVERFLOW_TRAP_EN
      trap <= trap_d;
`endif
    end
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer: directed vector table, reset corner cases,
// and randomized instructions checked against a table-lookup reference model.
module tb_dp_sequencer;

  localparam int unsigned E1 = 1;
  localparam int unsigned E3 = 3;
`ifdef OVERFLOW_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  r1, r2, wa;
    logic [3:0]  op;
    logic [15:0] imm;
    logic        sel, ill, we, trap;
  } exp_t;

  typedef struct {
    logic [31:0] w;
    logic        z, o, c;
    exp_t        e;
  } vec_t;

  logic clk, rst, rst3;
  logic instr_valid;
  logic [31:0] instr;
  logic zero_in, overflow_in, carry_in;

  logic instr_ready, reg_we, sel, zero_out, overflow_out, carry_out, illegal, done, busy;
  logic [4:0] read1, read2, write_addr;
  logic [3:0] alu_op;
  logic [15:0] inm;

  logic instr_ready3, reg_we3, sel3, zero_out3, overflow_out3, carry_out3, illegal3, done3, busy3;
  logic [4:0] read13, read23, write_addr3;
  logic [3:0] alu_op3;
  logic [15:0] inm3;
`ifdef OVERFLOW_TRAP_EN
  logic trap, trap3;
`endif

  dp_sequencer #(.EXEC_CYCLES(E1)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .read1(read1), .read2(read2), .write_addr(write_addr), .reg_we(reg_we), .alu_op(alu_op),
    .inm(inm), .sel(sel), .zero_in(zero_in), .overflow_in(overflow_in), .carry_in(carry_in),
    .zero_out(zero_out), .overflow_out(overflow_out), .carry_out(carry_out),
    .illegal(illegal), .done(done), .busy(busy)
`ifdef OVERFLOW_TRAP_EN
    , .trap(trap)
`endif
  );

  dp_sequencer #(.EXEC_CYCLES(E3)) dut3 (
    .clk(clk), .rst(rst3), .instr_valid(instr_valid), .instr_ready(instr_ready3), .instr(instr),
    .read1(read13), .read2(read23), .write_addr(write_addr3), .reg_we(reg_we3), .alu_op(alu_op3),
    .inm(inm3), .sel(sel3), .zero_in(zero_in), .overflow_in(overflow_in), .carry_in(carry_in),
    .zero_out(zero_out3), .overflow_out(overflow_out3), .carry_out(carry_out3),
    .illegal(illegal3), .done(done3), .busy(busy3)
`ifdef OVERFLOW_TRAP_EN
    , .trap(trap3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int we3_seen = 0, done3_seen = 0, done_seen = 0;
  logic [2:0] prev_flags;

  always @(posedge reg_we3) we3_seen++;
  always @(posedge done3)   done3_seen++;
  always @(posedge done)    done_seen++;

  logic [5:0] r_funct [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
  logic [3:0] r_op    [6] = '{4'h2,  4'h6,  4'h0,  4'h1,  4'hC,  4'h7};
  logic [5:0] i_opc   [4] = '{6'h08, 6'h0C, 6'h0D, 6'h0A};
  logic [3:0] i_op    [4] = '{4'h2,  4'h0,  4'h1,  4'h7};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Reference: look the instruction up in the mnemonic tables
  function automatic exp_t model(input logic [31:0] w, input logic ovf);
    exp_t e;
    logic arith;
    e = '0;
    e.r1 = w[25:21]; e.r2 = w[20:16]; e.imm = w[15:0]; e.ill = 1'b1;
    if (w[31:26] == 6'h00) begin
      for (int i = 0; i < 6; i++)
        if (w[5:0] == r_funct[i]) begin e.ill = 1'b0; e.op = r_op[i]; e.wa = w[15:11]; end
    end else begin
      for (int i = 0; i < 4; i++)
        if (w[31:26] == i_opc[i]) begin
          e.ill = 1'b0; e.op = i_op[i]; e.wa = w[20:16]; e.sel = 1'b1;
        end
    end
    arith  = !e.ill && (e.op == 4'h2 || e.op == 4'h6);
    e.trap = TRAP_ON && arith && ovf;
    e.we   = !e.ill && (e.wa != 5'd0) && !e.trap;
    return e;
  endfunction

  function automatic vec_t mk(input logic [31:0] w, input logic z, o, c,
                              input logic [4:0] r1, r2, wa, input logic [3:0] op,
                              input logic [15:0] imm, input logic s, ill, we, tr);
    vec_t v;
    v.w = w; v.z = z; v.o = o; v.c = c;
    v.e.r1 = r1; v.e.r2 = r2; v.e.wa = wa; v.e.op = op; v.e.imm = imm;
    v.e.sel = s; v.e.ill = ill; v.e.we = we; v.e.trap = tr;
    return v;
  endfunction

  task automatic run_txn(input logic [31:0] w, input logic z, o, c, input exp_t e, input bit noise);
    int wen, wcnt, dn, dcnt, rdy;
    wen = 0; wcnt = 0; dn = 0; dcnt = 0; rdy = 0;
    for (int i = 0; i < 20 && !instr_ready; i++) begin @(posedge clk); #1; end
    chk("ready_before_accept", 32'(instr_ready), 32'd1);
    zero_in = z; overflow_in = o; carry_in = c; instr = w; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("read1", 32'(read1), 32'(e.r1));
    chk("read2", 32'(read2), 32'(e.r2));
    chk("alu_op", 32'(alu_op), 32'(e.op));
    chk("inm", 32'(inm), 32'(e.imm));
    chk("illegal", 32'(illegal), 32'(e.ill));
    if (!e.ill) begin
      chk("write_addr", 32'(write_addr), 32'(e.wa));
      chk("sel", 32'(sel), 32'(e.sel));
    end
    chk("flags_hold_decode", 32'({zero_out, overflow_out, carry_out}), 32'(prev_flags));
    chk("decode_ctrl", 32'({busy, instr_ready, reg_we, done}), 32'b1000);
`ifdef OVERFLOW_TRAP_EN
    chk("trap_clear", 32'(trap), 32'd0);
`endif
    for (int n = 1; n <= 30; n++) begin
      if (noise && n <= int'(E1) + 3) begin
        instr_valid = 1'($urandom);
        instr = $urandom;
      end else instr_valid = 1'b0;
      @(posedge clk); #1;
      if (reg_we) begin wcnt++; wen = n; end
      if (done) begin
        dcnt++; dn = n;
        chk("flags_at_done", 32'({zero_out, overflow_out, carry_out}), 32'({z, o, c}));
        chk("decode_hold", {1'b0, read1, read2, alu_op, inm, illegal},
            {1'b0, e.r1, e.r2, e.op, e.imm, e.ill});
`ifdef OVERFLOW_TRAP_EN
        chk("trap_at_done", 32'(trap), 32'(e.trap));
`endif
      end
      if (instr_ready) begin rdy = n; break; end
    end
    instr_valid = 1'b0;
    chk("we_count", 32'(wcnt), 32'(e.we));
    if (e.we) chk("we_cycle", 32'(wen), 32'(E1 + 1));
    chk("done_count", 32'(dcnt), 32'd1);
    chk("done_cycle", 32'(dn), 32'(E1 + 2));
    chk("ready_cycle", 32'(rdy), 32'(E1 + 3));
    chk("flags_after", 32'({zero_out, overflow_out, carry_out}), 32'({z, o, c}));
    prev_flags = {z, o, c};
  endtask

  vec_t vecs [11];

  initial begin
    vecs[0]  = mk(32'h00221820, 0, 0, 0, 5'd1, 5'd2, 5'd3, 4'h2, 16'h1820, 0, 0, 1, 0);
    vecs[1]  = mk(32'h348500FF, 1, 0, 0, 5'd4, 5'd5, 5'd5, 4'h1, 16'h00FF, 1, 0, 1, 0);
    vecs[2]  = mk(32'hFC000000, 0, 0, 1, 5'd0, 5'd0, 5'd0, 4'h0, 16'h0000, 0, 1, 0, 0);
    vecs[3]  = mk(32'h00220020, 0, 0, 0, 5'd1, 5'd2, 5'd0, 4'h2, 16'h0020, 0, 0, 0, 0);
    vecs[4]  = mk(32'h00221822, 0, 1, 0, 5'd1, 5'd2, 5'd3, 4'h6, 16'h1822, 0, 0, !TRAP_ON, TRAP_ON);
    vecs[5]  = mk(32'h2022FFFF, 0, 0, 1, 5'd1, 5'd2, 5'd2, 4'h2, 16'hFFFF, 1, 0, 1, 0);
    vecs[6]  = mk(32'h0043202A, 1, 0, 1, 5'd2, 5'd3, 5'd4, 4'h7, 16'h202A, 0, 0, 1, 0);
    vecs[7]  = mk(32'h00221821, 0, 0, 0, 5'd1, 5'd2, 5'd0, 4'h0, 16'h1821, 0, 1, 0, 0);
    vecs[8]  = mk(32'h00A63827, 1, 1, 1, 5'd5, 5'd6, 5'd7, 4'hC, 16'h3827, 0, 0, 1, 0);
    vecs[9]  = mk(32'h31298000, 0, 1, 0, 5'd9, 5'd9, 5'd9, 4'h0, 16'h8000, 1, 0, 1, 0);
    vecs[10] = mk(32'h20200005, 0, 0, 0, 5'd1, 5'd0, 5'd0, 4'h2, 16'h0005, 1, 0, 0, 0);

    rst = 1'b1; rst3 = 1'b1; instr_valid = 1'b0; instr = '0;
    zero_in = 1'b0; overflow_in = 1'b0; carry_in = 1'b0; prev_flags = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_addr_bus", 32'({read1, read2, write_addr, alu_op}), 32'd0);
    chk("reset_ctrl", 32'({inm, reg_we, sel, zero_out, overflow_out, carry_out, illegal, done, busy}), 32'd0);
    @(negedge clk); rst = 1'b0; rst3 = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(instr_ready), 32'd1);
    chk("ready3_after_reset", 32'(instr_ready3), 32'd1);

    // Reset in the second EXEC cycle of the EXEC_CYCLES=3 instance
    we3_seen = 0; done3_seen = 0;
    instr = 32'h00221820; instr_valid = 1'b1;
    @(posedge clk); #1; instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("exec3_busy", 32'(busy3), 32'd1);
    rst3 = 1'b1; #1;
    chk("rst3_ctrl", 32'({busy3, reg_we3, done3}), 32'd0);
    @(negedge clk); rst3 = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    chk("rst3_no_we", 32'(we3_seen), 32'd0);
    chk("rst3_no_done", 32'(done3_seen), 32'd0);
    chk("rst3_ready", 32'(instr_ready3), 32'd1);

    // Reset during WB on the main instance: reg_we must drop without a clock edge
    instr = 32'h00221820; instr_valid = 1'b1;
    @(posedge clk); #1; instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("we_in_wb", 32'(reg_we), 32'd1);
    done_seen = 0;
    rst = 1'b1; #1;
    chk("rst_we_async", 32'({reg_we, busy, done}), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk("rst_no_done", 32'(done_seen), 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    prev_flags = '0;

    foreach (vecs[i]) run_txn(vecs[i].w, vecs[i].z, vecs[i].o, vecs[i].c, vecs[i].e, 1'b0);

    for (int t = 0; t < 80; t++) begin
      logic [31:0] w;
      logic z, o, c;
      int kind;
      w = $urandom;
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        w[31:26] = 6'h00;
        if ($urandom_range(0, 3) != 0) w[5:0] = r_funct[$urandom_range(0, 5)];
      end else if (kind < 5) begin
        w[31:26] = i_opc[kind - 1];
      end
      if ($urandom_range(0, 7) == 0) w[15:11] = 5'd0;
      if ($urandom_range(0, 7) == 0) w[20:16] = 5'd0;
      z = 1'($urandom); o = 1'($urandom); c = 1'($urandom);
      run_txn(w, z, o, c, model(w, o), 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
